// File: rtl/ppu_video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppu_video_pkg
// Description : Shared types and constants for the PPU-to-HDMI scan converter
//               pixel path: 5:5:5 colour struct, line/window geometry and
//               the frame-lock state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ppu_video_pkg;

   // PPU colour, blue in the MSBs: {b[4:0], g[4:0], r[4:0]}
   typedef struct packed {
      logic [4:0] b;
      logic [4:0] g;
      logic [4:0] r;
   } rgb15_t;

   localparam int LINE_PIXELS = 256;   // PPU pixels per scanline
   localparam int ACTIVE_W    = 512;   // active output window width
   localparam int X_W         = 10;    // width of the converter x coordinate

   // Frame-lock state
   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ARMED    = 2'd1,
      LOCKED   = 2'd2
   } lock_state_t;

endpackage : ppu_video_pkg
`default_nettype wire

// File: rtl/ppu_line_ram.sv
`default_nettype none
// ============================================================================
// Module      : ppu_line_ram
// Description : Two-bank simple dual-port line store (2 x DEPTH x 15 bits).
//               One write port, one read port, 1-cycle synchronous read with
//               read-old-data behaviour. Shaped to infer block RAM.
// Ports       : clk      - clock
//               wr_en    - write strobe
//               wr_bank  - bank selected for the write
//               wr_addr  - pixel index within the write bank
//               wr_data  - colour written
//               rd_bank  - bank selected for the read
//               rd_addr  - pixel index within the read bank
//               rd_data  - registered read data (valid the next cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_line_ram
   import ppu_video_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic          wr_bank,
   input  logic [AW-1:0] wr_addr,
   input  rgb15_t        wr_data,
   input  logic          rd_bank,
   input  logic [AW-1:0] rd_addr,
   output rgb15_t        rd_data
);

   // Bank number is the address MSB so both banks live in one array
   rgb15_t mem [0:2*DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[{wr_bank, wr_addr}] <= wr_data;
      end
      rd_data <= mem[{rd_bank, rd_addr}];
   end

endmodule : ppu_line_ram
`default_nettype wire

// File: rtl/ppu_line_doubler.sv
`default_nettype none
// ============================================================================
// Module      : ppu_line_doubler
// Description : Captures 256-pixel PPU scanlines into a ping-pong line buffer
//               and serves the scan converter's per-cycle pixel requests with
//               2x horizontal scaling and each PPU line shown on two output
//               lines. Locks the output frame to the PPU frame via sync.
// Ports       : clk             - system clock
//               reset           - asynchronous active-high reset
//               ppu_pixel       - PPU colour {b,g,r}
//               ppu_valid       - ppu_pixel valid this cycle
//               ppu_line_start  - pulse before the first pixel of a line
//               ppu_frame_start - pulse at PPU scanline 0 (with line_start)
//               next_pixel_x    - output x needed next cycle
//               vga_line_end    - converter finished an output line
//               pixel           - colour for the current cycle
//               sync            - one-cycle frame-alignment pulse
//               border          - current pixel outside the active window
//               overflow        - sticky: too many pixels in one line
// Options     : PPU_LINE_DOUBLER_SCANLINE_DIM_EN - halve every colour channel
//               on the repeated (second) output line of each PPU line.
// Revision    : 1.0 - initial release
// ============================================================================
module ppu_line_doubler #(
   parameter int          H_OFFSET     = 64,
   parameter logic [14:0] BORDER_COLOR = 15'h0000,
   parameter int          LINE_PIXELS  = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [14:0] ppu_pixel,
   input  logic        ppu_valid,
   input  logic        ppu_line_start,
   input  logic        ppu_frame_start,
   input  logic [9:0]  next_pixel_x,
   input  logic        vga_line_end,
   output logic [14:0] pixel,
   output logic        sync,
   output logic        border,
   output logic        overflow
);
   import ppu_video_pkg::*;

   localparam int          AW        = $clog2(LINE_PIXELS);
   localparam logic [AW:0] LINE_FULL = (AW+1)'(LINE_PIXELS);
   localparam logic [X_W:0] WIN_LO   = (X_W+1)'(H_OFFSET);
   localparam logic [X_W:0] WIN_HI   = (X_W+1)'(H_OFFSET + ACTIVE_W);

   // ------------------------------------------------------------------
   // Write side
   // ------------------------------------------------------------------
   logic [AW:0]   wr_x;
   logic          wr_bank;
   logic          commit;
   logic          wr_en;
   logic          wr_bank_eff;
   logic [AW-1:0] wr_addr;

   // A line is only handed to the reader if at least one pixel landed in it
   assign commit = ppu_line_start && (wr_x != '0);

   // line_start takes effect before a pixel arriving in the same cycle, so
   // that pixel goes to x=0 of the freshly selected bank
   assign wr_bank_eff = commit ? ~wr_bank : wr_bank;
   assign wr_addr     = ppu_line_start ? '0 : wr_x[AW-1:0];
   assign wr_en       = ppu_valid && (ppu_line_start || (wr_x < LINE_FULL));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_x     <= '0;
         wr_bank  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (commit) begin
            wr_bank <= ~wr_bank;
         end
         if (ppu_line_start) begin
            wr_x <= ppu_valid ? (AW+1)'(1) : '0;
         end else if (ppu_valid) begin
            if (wr_x < LINE_FULL) begin
               wr_x <= wr_x + (AW+1)'(1);
            end else begin
               overflow <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Bank hand-over, line doubling and frame lock
   // ------------------------------------------------------------------
   logic        rd_bank;
   logic        rd_pending;
   logic        pending;
   logic        half;
   logic        frame_seen;
   lock_state_t state;
   logic        swap_now;
   logic        pend_any;
   logic        pend_bank;

   // A commit in the same cycle counts as pending before the swap decision
   assign pend_any  = pending || commit;
   assign pend_bank = commit ? wr_bank : rd_pending;
   assign swap_now  = vga_line_end && half;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_bank    <= 1'b1;
         rd_pending <= 1'b0;
         pending    <= 1'b0;
         half       <= 1'b0;
         frame_seen <= 1'b0;
         state      <= UNLOCKED;
         sync       <= 1'b0;
      end else begin
         sync <= 1'b0;

         if (commit) begin
            rd_pending <= wr_bank;
         end

         if (vga_line_end) begin
            half <= ~half;
         end

         if (swap_now) begin
            // With nothing pending the current bank is simply shown again
            if (pend_any) begin
               rd_bank <= pend_bank;
            end
            pending <= 1'b0;
         end else if (commit) begin
            pending <= 1'b1;
         end

         // Later assignments to half intentionally win over the toggle above
         case (state)
            UNLOCKED: begin
               if (ppu_frame_start) begin
                  state <= ARMED;
               end
            end
            ARMED: begin
               if (commit) begin
                  sync  <= 1'b1;
                  half  <= 1'b0;
                  state <= LOCKED;
               end
            end
            LOCKED: begin
               // The commit coinciding with frame_start closes the previous
               // frame; sync follows the first commit after it
               if (commit && frame_seen) begin
                  sync <= 1'b1;
               end
               if (ppu_frame_start) begin
                  frame_seen <= 1'b1;
               end else if (commit) begin
                  frame_seen <= 1'b0;
               end
            end
            default: begin
               state <= UNLOCKED;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Read side: request decoded this cycle, answered next cycle
   // ------------------------------------------------------------------
   logic [X_W:0]  x_ext;
   logic          in_win;
   logic [AW-1:0] src;
   rgb15_t        rd_data;
   rgb15_t        color;

   assign x_ext  = {1'b0, next_pixel_x};
   assign in_win = (x_ext >= WIN_LO) && (x_ext < WIN_HI);
   assign src    = AW'((next_pixel_x - X_W'(H_OFFSET)) >> 1);

   ppu_line_ram #(
      .DEPTH (LINE_PIXELS),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_bank (wr_bank_eff),
      .wr_addr (wr_addr),
      .wr_data (ppu_pixel),
      .rd_bank (rd_bank),
      .rd_addr (src),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         border <= 1'b1;
      end else begin
         border <= ~in_win;
      end
   end

`ifdef PPU_LINE_DOUBLER_SCANLINE_DIM_EN
   logic dim;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dim <= 1'b0;
      end else begin
         dim <= half;
      end
   end

   always_comb begin
      color = rd_data;
      if (dim) begin
         color.b = rd_data.b >> 1;
         color.g = rd_data.g >> 1;
         color.r = rd_data.r >> 1;
      end
   end
`else
   assign color = rd_data;
`endif

   // border is reset high, so pixel shows BORDER_COLOR out of reset
   assign pixel = border ? BORDER_COLOR : color;

endmodule : ppu_line_doubler
`default_nettype wire

// File: tb/tb_ppu_line_doubler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppu_line_doubler
// Description : Self-checking bench for ppu_line_doubler. A behavioural
//               line-buffer model predicts pixel/border/sync/overflow every
//               cycle; directed sections pin the model with literal values,
//               followed by randomized traffic.
// Options     : PPU_LINE_DOUBLER_SCANLINE_DIM_EN - expects dimmed repeats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppu_line_doubler;

   localparam int          H  = 64;
   localparam logic [14:0] BC = 15'h0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [14:0] ppu_pixel = '0;
   logic        ppu_valid = 1'b0;
   logic        ppu_line_start = 1'b0;
   logic        ppu_frame_start = 1'b0;
   logic [9:0]  next_pixel_x = '0;
   logic        vga_line_end = 1'b0;
   logic [14:0] pixel;
   logic        sync;
   logic        border;
   logic        overflow;

   always #5 clk = ~clk;

   ppu_line_doubler dut (
      .clk             (clk),
      .reset           (reset),
      .ppu_pixel       (ppu_pixel),
      .ppu_valid       (ppu_valid),
      .ppu_line_start  (ppu_line_start),
      .ppu_frame_start (ppu_frame_start),
      .next_pixel_x    (next_pixel_x),
      .vga_line_end    (vga_line_end),
      .pixel           (pixel),
      .sync            (sync),
      .border          (border),
      .overflow        (overflow)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: two line banks, a pending-line slot, half flag
   // ------------------------------------------------------------------
   logic [14:0] m_mem   [2][256];
   bit          m_known [2][256];
   int          m_wr_x;
   bit          m_wr_bank, m_rd_bank, m_pend, m_pend_bank, m_half, m_ovf, m_fflag;
   int          m_state;            // 0 unlocked, 1 armed, 2 locked
   logic [14:0] exp_pix;
   bit          exp_border, exp_sync, exp_known, exp_ovf;

   always @(posedge clk or posedge reset) begin : model
      bit          commit;
      int          idx;
      logic [14:0] v;
      if (reset) begin
         m_wr_x = 0; m_wr_bank = 0; m_rd_bank = 1; m_pend = 0; m_pend_bank = 0;
         m_half = 0; m_ovf = 0; m_state = 0; m_fflag = 0;
         exp_pix = BC; exp_border = 1; exp_sync = 0; exp_known = 1; exp_ovf = 0;
      end else begin
         exp_sync = 0;
         // output for the request presented this cycle, from the old contents
         if (int'(next_pixel_x) >= H && int'(next_pixel_x) < H + 512) begin
            idx        = (int'(next_pixel_x) - H) / 2;
            v          = m_mem[m_rd_bank][idx];
            exp_known  = m_known[m_rd_bank][idx];
`ifdef PPU_LINE_DOUBLER_SCANLINE_DIM_EN
            if (m_half) v = {5'(v[14:10] / 2), 5'(v[9:5] / 2), 5'(v[4:0] / 2)};
`endif
            exp_pix    = v;
            exp_border = 0;
         end else begin
            exp_pix = BC; exp_border = 1; exp_known = 1;
         end
         // capture
         commit = ppu_line_start && (m_wr_x != 0);
         if (commit) begin
            m_pend = 1; m_pend_bank = m_wr_bank; m_wr_bank = !m_wr_bank;
         end
         if (ppu_line_start) m_wr_x = 0;
         if (ppu_valid) begin
            if (m_wr_x < 256) begin
               m_mem[m_wr_bank][m_wr_x]   = ppu_pixel;
               m_known[m_wr_bank][m_wr_x] = 1;
               m_wr_x++;
            end else begin
               m_ovf = 1;
            end
         end
         // doubling
         if (vga_line_end) begin
            if (!m_half) m_half = 1;
            else begin
               m_half = 0;
               if (m_pend) begin m_rd_bank = m_pend_bank; m_pend = 0; end
            end
         end
         // frame lock
         case (m_state)
            0: if (ppu_frame_start) m_state = 1;
            1: if (commit) begin exp_sync = 1; m_half = 0; m_state = 2; end
            default: begin
               if (commit && m_fflag) exp_sync = 1;
               if (ppu_frame_start) m_fflag = 1;
               else if (commit) m_fflag = 0;
            end
         endcase
         exp_ovf = m_ovf;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_border", border, exp_border);
         chk("model_sync", sync, exp_sync);
         chk("model_overflow", overflow, exp_ovf);
         if (exp_known) chk("model_pixel", pixel, exp_pix);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_px(input int n, input logic [14:0] base, input bit inc);
      for (int i = 0; i < n; i++) begin
         ppu_valid = 1'b1;
         ppu_pixel = inc ? base + 15'(i) : base;
         step();
      end
      ppu_valid = 1'b0;
   endtask

   task automatic line_start_pulse();
      ppu_line_start = 1'b1;
      step();
      ppu_line_start = 1'b0;
   endtask

   task automatic line_end_pulse();
      vga_line_end = 1'b1;
      step();
      vga_line_end = 1'b0;
   endtask

   task automatic read_chk(input string nm, input logic [9:0] x, input logic [14:0] exp);
      next_pixel_x = x;
      step();
      chk(nm, pixel, exp);
      chk({nm, "_border"}, border, 1'b0);
      next_pixel_x = '0;
   endtask

   initial begin : watchdog
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin : main
      logic [14:0] dim_exp;
      #2;
      reset  = 1'b1;
      cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_pixel", pixel, 15'h0000);
      chk("reset_border", border, 1'b1);
      chk("reset_sync", sync, 1'b0);
      chk("reset_overflow", overflow, 1'b0);
      reset = 1'b0;
      step();

      // Line of pixel = x, committed and brought to the reader
      line_start_pulse();
      write_px(256, 15'h0000, 1'b1);
      line_start_pulse();
      line_end_pulse();
      line_end_pulse();
      for (int x = 0; x < 640; x++) begin
         next_pixel_x = 10'(x);
         step();
         case (x)
            63, 576: begin
               chk("sweep_edge_border", border, 1'b1);
               chk("sweep_edge_pixel", pixel, 15'h0000);
            end
            64:  chk("sweep_x64", pixel, 15'd0);
            65:  chk("sweep_x65", pixel, 15'd0);
            66:  chk("sweep_x66", pixel, 15'd1);
            575: chk("sweep_x575", pixel, 15'd255);
            default: ;
         endcase
      end
      next_pixel_x = '0;

      // Doubling: A shown twice, then B, then B repeated on underrun
`ifdef PPU_LINE_DOUBLER_SCANLINE_DIM_EN
      dim_exp = 15'h3DEF;
`else
      dim_exp = 15'h7FFF;
`endif
      write_px(256, 15'h7FFF, 1'b0);
      line_start_pulse();
      line_end_pulse();
      line_end_pulse();
      write_px(256, 15'h0100, 1'b1);
      line_start_pulse();
      read_chk("double_a_first", 10'd66, 15'h7FFF);
      line_end_pulse();
      read_chk("double_a_repeat", 10'd66, dim_exp);
      line_end_pulse();
      read_chk("double_b_x66", 10'd66, 15'h0101);
      read_chk("double_b_x575", 10'd575, 15'h01FF);
      line_end_pulse();
      line_end_pulse();
      read_chk("underrun_b_again", 10'd66, 15'h0101);
      chk("underrun_overflow", overflow, 1'b0);

      // Overflow: 300 pixels in one line
      write_px(300, 15'h2000, 1'b1);
      chk("overflow_set", overflow, 1'b1);
      line_start_pulse();
      write_px(10, 15'h0040, 1'b1);
      line_start_pulse();
      step();
      chk("overflow_sticky", overflow, 1'b1);

      // Frame lock
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("overflow_cleared", overflow, 1'b0);
      ppu_frame_start = 1'b1;
      ppu_line_start  = 1'b1;
      step();
      ppu_frame_start = 1'b0;
      ppu_line_start  = 1'b0;
      write_px(256, 15'h0333, 1'b1);
      chk("sync_before_commit", sync, 1'b0);
      line_start_pulse();
      chk("sync_pulse", sync, 1'b1);
      step();
      chk("sync_one_cycle", sync, 1'b0);

      // Reset in the middle of a line while reading the active window
      next_pixel_x = 10'd100;
      write_px(20, 15'h0555, 1'b1);
      chk("pre_reset_border", border, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("midreset_pixel", pixel, 15'h0000);
      chk("midreset_border", border, 1'b1);
      chk("midreset_sync", sync, 1'b0);
      step();
      reset = 1'b0;
      next_pixel_x = '0;
      write_px(10, 15'h0666, 1'b1);
      line_start_pulse();
      chk("unlocked_no_sync", sync, 1'b0);
      step();

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         ppu_valid       = ($urandom % 4) != 0;
         ppu_pixel       = 15'($urandom);
         ppu_line_start  = ($urandom % 180) == 0;
         ppu_frame_start = ppu_line_start && (($urandom % 6) == 0);
         vga_line_end    = ($urandom % 120) == 0;
         next_pixel_x    = 10'($urandom_range(0, 700));
         if (($urandom % 1500) == 0) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
         end
         step();
      end
      ppu_valid       = 1'b0;
      ppu_line_start  = 1'b0;
      ppu_frame_start = 1'b0;
      vga_line_end    = 1'b0;
      next_pixel_x    = '0;
      repeat (3) step();
      cmp_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_ppu_line_doubler
`default_nettype wire
